bist_sig_ctrl: RTL and testbench

BIST sequencer and signature checker sitting directly downstream of the 8-bit MISR (`lfsr`). It starts a self-test run, clears the MISR, and enables the test-pattern source for a programmed number of cycles. It then waits for the CUT/MISR pipeline to drain, captures the MISR signature and compares it against a golden value, reporting done/pass to the system.

---
 rtl/bist_sig_ctrl.sv | 162 ++++++++++++++++
 tb/tb_bist_sig_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bist_sig_ctrl.sv
// BIST sequencer and signature checker for an 8-bit MISR: clears the MISR, runs the
// pattern source for N cycles, drains the pipeline, then captures and judges the signature.
module bist_sig_ctrl #(
    parameter int SIG_W    = 8,
    parameter int CNT_W    = 8,
    parameter int PIPE_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [SIG_W-1:0] golden,
    input  logic [SIG_W-1:0] sig_in,
    output logic             misr_clr,
    output logic             tpg_en,
    output logic             test_mode,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_SETTLE  = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       DRAIN_INIT = 4'(PIPE_LAT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       drain_q, drain_d;
    logic [SIG_W-1:0] gold_q, gold_d;
    logic [SIG_W-1:0] signature_q, signature_d;
    logic             pass_q, pass_d;
    logic             misr_clr_q, misr_clr_d;
    logic             tpg_en_q, tpg_en_d;
    logic             test_mode_q, test_mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state, counters and result capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        gold_d      = gold_q;
        signature_d = signature_q;
        pass_d      = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d       = num_patterns;
                    gold_d      = golden;
                    pass_d      = 1'b0;
                    signature_d = '0;
                    state_d     = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (cnt_q == '0) begin
                    drain_d = DRAIN_INIT;
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Guarded decrement so the counter can never wrap below zero.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
                if (cnt_q <= CNT_ONE) begin
                    drain_d = DRAIN_INIT;
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_SETTLE: begin
                if (drain_q != 4'd0) begin
                    drain_d = drain_q - 4'd1;
                end else begin
                    drain_d = drain_q;
                end
                if (drain_q <= 4'd1) begin
                    state_d = S_COMPARE;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_COMPARE: begin
                signature_d = sig_in;
                pass_d      = (sig_in == gold_q);
                state_d     = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control outputs are decoded from the next state so the flops line up with the state
    always_comb begin
        misr_clr_d  = (state_d == S_CLEAR);
        tpg_en_d    = (state_d == S_RUN);
        test_mode_d = (state_d == S_CLEAR) || (state_d == S_RUN) ||
                      (state_d == S_SETTLE) || (state_d == S_COMPARE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            drain_q     <= 4'd0;
            gold_q      <= '0;
            signature_q <= '0;
            pass_q      <= 1'b0;
            misr_clr_q  <= 1'b0;
            tpg_en_q    <= 1'b0;
            test_mode_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            gold_q      <= gold_d;
            signature_q <= signature_d;
            pass_q      <= pass_d;
            misr_clr_q  <= misr_clr_d;
            tpg_en_q    <= tpg_en_d;
            test_mode_q <= test_mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign misr_clr  = misr_clr_q;
    assign tpg_en    = tpg_en_q;
    assign test_mode = test_mode_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = signature_q;

endmodule

// File: tb/tb_bist_sig_ctrl.sv
// Scoreboard bench for bist_sig_ctrl: a behavioural MISR feeds sig_in, runs push expected
// done cycle / pass / signature, and a negedge monitor checks each done pulse.
module tb_bist_sig_ctrl;

    localparam int SIG_W    = 8;
    localparam int CNT_W    = 8;
    localparam int PIPE_LAT = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_patterns = '0;
    logic [SIG_W-1:0] golden = '0;
    logic [SIG_W-1:0] sig_in;
    logic             misr_clr, tpg_en, test_mode, busy, done, pass;
    logic [SIG_W-1:0] signature;

    bist_sig_ctrl #(.SIG_W(SIG_W), .CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .num_patterns(num_patterns),
        .golden(golden), .sig_in(sig_in), .misr_clr(misr_clr), .tpg_en(tpg_en),
        .test_mode(test_mode), .busy(busy), .done(done), .pass(pass),
        .signature(signature)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural MISR driven by the DUT's clear / enable
    logic [7:0] misr_q = 8'h00;
    logic [7:0] misr_k = 8'h00;

    function automatic logic [7:0] misr_step(input logic [7:0] q, input logic [7:0] d);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]} ^ d;
    endfunction

    function automatic logic [7:0] pat(input logic [7:0] k);
        return 8'(k * 8'd37 + 8'd11);
    endfunction

    function automatic logic [7:0] misr_exp(input int n);
        logic [7:0] q;
        q = 8'h00;
        for (int i = 0; i < n; i++) q = misr_step(q, pat(8'(i)));
        return q;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            misr_q <= 8'h00;
            misr_k <= 8'h00;
        end else if (misr_clr) begin
            misr_q <= 8'h00;
            misr_k <= 8'h00;
        end else if (tpg_en) begin
            misr_q <= misr_step(misr_q, pat(misr_k));
            misr_k <= misr_k + 8'd1;
        end
    end
    assign sig_in = misr_q;

    typedef struct {
        int         cyc;
        logic       p;
        logic [7:0] sig;
        int         n;
    } exp_t;
    exp_t sbq[$];

    int total = 0;
    int bad   = 0;
    int tpg_cnt = 0;
    int clr_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts enables per run and checks every done pulse against the queue
    always @(negedge clk) begin
        exp_t e;
        if (tpg_en) tpg_cnt++;
        if (misr_clr) clr_cnt++;
        if (done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("pass", {31'd0, pass}, {31'd0, e.p});
                chk("signature", {24'd0, signature}, {24'd0, e.sig});
                chk("tpg_en_cycles", tpg_cnt, e.n);
                chk("misr_clr_cycles", clr_cnt, 32'd1);
                chk("test_mode_at_done", {31'd0, test_mode}, 32'd0);
            end
            tpg_cnt = 0;
            clr_cnt = 0;
        end
    end

    task automatic run_start(input int n, input logic [7:0] g, input logic p, input bit hold);
        exp_t e;
        start        = 1'b1;
        num_patterns = 8'(n);
        golden       = g;
        e.cyc = cyc + n + 3 + PIPE_LAT;
        e.p   = p;
        e.sig = misr_exp(n);
        e.n   = n;
        sbq.push_back(e);
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (sbq.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sbq.size() != 0) begin
            chk("run_timeout", sbq.size(), 32'd0);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outputs"}, {26'd0, misr_clr, tpg_en, test_mode, busy, done, pass}, 32'd0);
        chk({tag, "_signature"}, {24'd0, signature}, 32'd0);
    endtask

    initial begin
        int s;
        logic [7:0] g16;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Matching run, then result held in IDLE
        g16 = misr_exp(16);
        run_start(16, g16, 1'b1, 1'b0);
        wait_idle(200);
        repeat (3) @(negedge clk);
        chk("held_pass_match", {31'd0, pass}, 32'd1);
        chk("held_sig_match", {24'd0, signature}, {24'd0, g16});
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Mismatching golden
        run_start(16, g16 ^ 8'h5A, 1'b0, 1'b0);
        wait_idle(200);
        repeat (5) @(negedge clk);
        chk("held_pass_mismatch", {31'd0, pass}, 32'd0);
        chk("held_sig_mismatch", {24'd0, signature}, {24'd0, g16});

        // Zero patterns: cleared MISR captured
        run_start(0, 8'h00, 1'b1, 1'b0);
        wait_idle(50);
        chk("zero_sig", {24'd0, signature}, 32'h0000_0000);

        // Reset in cycle 50 of a 200-pattern run
        s = cyc;
        run_start(200, 8'h00, 1'b0, 1'b0);
        while (cyc < s + 50) @(negedge clk);
        chk("midrun_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk_all_zero("midrun_reset");
        sbq.delete();
        tpg_cnt = 0;
        clr_cnt = 0;
        repeat (250) @(negedge clk);
        run_start(5, misr_exp(5), 1'b1, 1'b0);
        wait_idle(50);

        // Inputs changed mid-run are ignored
        run_start(10, misr_exp(10), 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        num_patterns = 8'd3;
        golden       = 8'hFF;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(100);
        repeat (20) @(negedge clk);

        // Back-to-back with start held: done every 9 cycles
        begin
            exp_t e;
            s = cyc;
            run_start(4, misr_exp(4), 1'b1, 1'b1);
            for (int r = 1; r < 3; r++) begin
                e.cyc = s + 8 + 9 * r;
                e.p   = 1'b1;
                e.sig = misr_exp(4);
                e.n   = 4;
                sbq.push_back(e);
            end
            while (cyc < s + 20) @(negedge clk);
            start = 1'b0;
            wait_idle(100);
            repeat (15) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
